// File: rtl/video_ram_writer_if.sv
// Pixel valid/ready handshake between the fractal engine
// and the video RAM writer.
interface video_ram_writer_if #(
    parameter int unsigned HCW  = 12,
    parameter int unsigned VCW  = 12,
    parameter int unsigned IMDW = 8
);
    logic            in_vld;
    logic            in_rdy;
    logic [HCW-1:0]  in_x;
    logic [VCW-1:0]  in_y;
    logic [IMDW-1:0] in_dat;

    modport master (
        output in_vld, in_x, in_y, in_dat,
        input  in_rdy
    );

    modport slave (
        input  in_vld, in_x, in_y, in_dat,
        output in_rdy
    );
endinterface

// File: rtl/video_ram_writer.sv
// Write-side front end of the video index RAM: pixel FIFO + frame clear.
// Drop statistics enabled by VIDEO_RAM_WRITER_STATS_EN.
module video_ram_writer #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned HCW      = 12,
    parameter int unsigned VCW      = 12,
    parameter int unsigned IMAW     = 19,
    parameter int unsigned IMDW     = 8,
    parameter int unsigned FD       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en_i,
    input  logic             clr_i,
    input  logic [IMDW-1:0]  clr_val_i,
    video_ram_writer_if.slave pix,
    output logic             busy_o,
    output logic             done_o,
    output logic [15:0]      drop_cnt_o,
    output logic             vram_we_o,
    output logic [IMAW-1:0]  vram_adr_w_o,
    output logic [IMDW-1:0]  vram_dat_w_o
);
    localparam int unsigned PW   = $clog2(FD);
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned LW   = HCW + VCW + 32;
    localparam int unsigned KW   = IMAW + 1;
    localparam int unsigned NPIX = H_ACTIVE * V_ACTIVE;
    localparam int unsigned EW   = IMAW + IMDW;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            s1_vld_q;
    logic [IMAW-1:0] s1_adr_q;
    logic [IMDW-1:0] s1_dat_q;
    logic [EW-1:0]   mem_q [FD];
    logic [PW-1:0]   wp_q, rp_q;
    logic [CW-1:0]   cnt_q;
    logic [KW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [IMDW-1:0] clr_val_q;
    logic            we_q, we_d;
    logic [IMAW-1:0] adr_q, adr_d;
    logic [IMDW-1:0] dat_q, dat_d;
    logic            done_q, done_d;
    logic            xfer, in_range, push, pop;
    logic [IMAW-1:0] lin_adr;

    // product and sum at full width, truncated only at the end
    assign lin_adr = IMAW'(LW'(pix.in_y) * LW'(H_ACTIVE)
                     + LW'(pix.in_x));
    assign in_range = (LW'(pix.in_x) < LW'(H_ACTIVE))
                   && (LW'(pix.in_y) < LW'(V_ACTIVE));

    assign pix.in_rdy = (state_q == S_RUN) && clk_en_i
                     && ((cnt_q + CW'(s1_vld_q)) < CW'(FD));
    assign xfer = pix.in_vld && pix.in_rdy;
    assign push = s1_vld_q;
    assign pop  = (state_q != S_CLEAR) && (cnt_q != '0);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        we_d      = 1'b0;
        adr_d     = adr_q;
        dat_d     = dat_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_RUN, S_DRAIN: begin
                if (pop) begin
                    we_d           = 1'b1;
                    {adr_d, dat_d} = mem_q[rp_q];
                end
                if (state_q == S_RUN && clr_i) begin
                    state_d = S_DRAIN;
                end
                if (state_q == S_DRAIN && !s1_vld_q
                    && cnt_q == '0) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            S_CLEAR: begin
                // one idle cycle after the last write hands back to RUN
                if (clr_cnt_q == KW'(NPIX)) begin
                    state_d = S_RUN;
                end else begin
                    we_d      = 1'b1;
                    adr_d     = clr_cnt_q[IMAW-1:0];
                    dat_d     = clr_val_q;
                    done_d    = (clr_cnt_q == KW'(NPIX - 1));
                    clr_cnt_d = clr_cnt_q + KW'(1);
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RUN;
            s1_vld_q  <= 1'b0;
            s1_adr_q  <= '0;
            s1_dat_q  <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
            clr_cnt_q <= '0;
            clr_val_q <= '0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            done_q    <= 1'b0;
        end else if (clk_en_i) begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            done_q    <= done_d;
            s1_vld_q  <= xfer && in_range;
            if (xfer) begin
                s1_adr_q <= lin_adr;
                s1_dat_q <= pix.in_dat;
            end
            if (state_q == S_RUN && clr_i) begin
                clr_val_q <= clr_val_i;
            end
            if (push) begin
                wp_q <= wp_q + PW'(1);
            end
            if (pop) begin
                rp_q <= rp_q + PW'(1);
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en_i && push) begin
            mem_q[wp_q] <= {s1_adr_q, s1_dat_q};
        end
    end

`ifdef VIDEO_RAM_WRITER_STATS_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else if (xfer && !in_range && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_cnt_o = drop_q;
`else
    assign drop_cnt_o = '0;
`endif

    assign busy_o = (state_q != S_RUN) || s1_vld_q
                 || (cnt_q != '0);
    assign done_o       = done_q;
    assign vram_we_o    = we_q;
    assign vram_adr_w_o = adr_q;
    assign vram_dat_w_o = dat_q;
endmodule

// File: tb/tb_video_ram_writer.sv
// Directed bench for video_ram_writer: a full-size instance and a
// 16x8 instance used for complete frame clears.
module tb_video_ram_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic        clr = 1'b0;
    logic        vld = 1'b0;
    logic        sel = 1'b0;
    logic [11:0] px  = '0;
    logic [11:0] py  = '0;
    logic [7:0]  pd  = '0;
    logic [7:0]  cv  = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    video_ram_writer_if #(.HCW(12), .VCW(12), .IMDW(8)) pa ();
    video_ram_writer_if #(.HCW(12), .VCW(12), .IMDW(8)) pb ();

    assign pa.in_vld = vld & ~sel;
    assign pa.in_x   = px;
    assign pa.in_y   = py;
    assign pa.in_dat = pd;
    assign pb.in_vld = vld & sel;
    assign pb.in_x   = px;
    assign pb.in_y   = py;
    assign pb.in_dat = pd;

    logic        busy_a, done_a, we_a;
    logic [15:0] drop_a;
    logic [18:0] adr_a;
    logic [7:0]  dat_a;
    logic        busy_b, done_b, we_b;
    logic [15:0] drop_b;
    logic [18:0] adr_b;
    logic [7:0]  dat_b;

    video_ram_writer dut_a (
        .clk          (clk),
        .rst          (rst),
        .clk_en_i     (en),
        .clr_i        (clr & ~sel),
        .clr_val_i    (cv),
        .pix          (pa),
        .busy_o       (busy_a),
        .done_o       (done_a),
        .drop_cnt_o   (drop_a),
        .vram_we_o    (we_a),
        .vram_adr_w_o (adr_a),
        .vram_dat_w_o (dat_a)
    );

    video_ram_writer #(.H_ACTIVE(16), .V_ACTIVE(8)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .clk_en_i     (en),
        .clr_i        (clr & sel),
        .clr_val_i    (cv),
        .pix          (pb),
        .busy_o       (busy_b),
        .done_o       (done_b),
        .drop_cnt_o   (drop_b),
        .vram_we_o    (we_b),
        .vram_adr_w_o (adr_b),
        .vram_dat_w_o (dat_b)
    );

    logic        rdy_m, we_m, done_m, busy_m;
    logic [18:0] adr_m;
    logic [7:0]  dat_m;
    assign rdy_m  = sel ? pb.in_rdy : pa.in_rdy;
    assign we_m   = sel ? we_b : we_a;
    assign done_m = sel ? done_b : done_a;
    assign busy_m = sel ? busy_b : busy_a;
    assign adr_m  = sel ? adr_b : adr_a;
    assign dat_m  = sel ? dat_b : dat_a;

    // samples one cycle just before its edge, then advances past it
    task automatic tick(
        output logic xf, output logic wr,
        output logic [18:0] wa, output logic [7:0] wd,
        output logic rdy, output logic dn, output logic bz
    );
        #1;
        rdy = rdy_m;
        xf  = vld && rdy_m;
        wr  = we_m && en;
        wa  = adr_m;
        wd  = dat_m;
        dn  = done_m && en;
        bz  = busy_m;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        total++;
        if (we_a !== 1'b0 || we_b !== 1'b0) begin
            bad++;
            $display("FAIL rst_we: got %b/%b want 0", we_a, we_b);
        end
        total++;
        if (adr_a !== 19'd0 || dat_a !== 8'd0) begin
            bad++;
            $display("FAIL rst_adr_dat: got %0d/%h want 0/0",
                     adr_a, dat_a);
        end
        total++;
        if (done_a !== 1'b0 || drop_a !== 16'd0) begin
            bad++;
            $display("FAIL rst_done_drop: got %b/%0d want 0/0",
                     done_a, drop_a);
        end
        total++;
        if (busy_a !== 1'b0) begin
            bad++;
            $display("FAIL rst_busy: got %b want 0", busy_a);
        end
        total++;
        if (pa.in_rdy !== 1'b1) begin
            bad++;
            $display("FAIL rst_rdy: got %b want 1", pa.in_rdy);
        end
    endtask

    task automatic test_latency();
        logic xf, wr, rdy, dn, bz;
        logic [18:0] wa, fa;
        logic [7:0] wd, fd;
        int first;
        sel = 1'b0;
        px = 12'd5; py = 12'd2; pd = 8'h3C; vld = 1'b1;
        tick(xf, wr, wa, wd, rdy, dn, bz);
        vld = 1'b0;
        total++;
        if (xf !== 1'b1) begin
            bad++;
            $display("FAIL lat_xfer: got %b want 1", xf);
        end
        first = -1; fa = '0; fd = '0;
        for (int k = 1; k < 8; k++) begin
            tick(xf, wr, wa, wd, rdy, dn, bz);
            if (wr && first < 0) begin
                first = k; fa = wa; fd = wd;
            end
        end
        total++;
        if (first !== 3) begin
            bad++;
            $display("FAIL lat_cycles: got %0d want 3", first);
        end
        total++;
        if (fa !== 19'd1605 || fd !== 8'h3C) begin
            bad++;
            $display("FAIL lat_write: got %0d/%h want 1605/3c",
                     fa, fd);
        end
    endtask

    task automatic test_range();
        logic xf, wr, rdy, dn, bz;
        logic [18:0] wa, la;
        logic [7:0] wd, ld;
        int nw, nx;
        logic [15:0] exp_drop;
`ifdef VIDEO_RAM_WRITER_STATS_EN
        exp_drop = 16'd1;
`else
        exp_drop = 16'd0;
`endif
        sel = 1'b0; nw = 0; nx = 0; la = '0; ld = '0;
        px = 12'd799; py = 12'd599; pd = 8'hFF; vld = 1'b1;
        tick(xf, wr, wa, wd, rdy, dn, bz);
        if (xf) nx++;
        px = 12'd800; py = 12'd0; pd = 8'h11;
        tick(xf, wr, wa, wd, rdy, dn, bz);
        if (xf) nx++;
        vld = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(xf, wr, wa, wd, rdy, dn, bz);
            if (wr) begin
                nw++; la = wa; ld = wd;
            end
        end
        total++;
        if (nx !== 2) begin
            bad++;
            $display("FAIL rng_xfers: got %0d want 2", nx);
        end
        total++;
        if (nw !== 1 || la !== 19'd479999 || ld !== 8'hFF) begin
            bad++;
            $display("FAIL rng_write: got n=%0d %0d/%h want 1 479999/ff",
                     nw, la, ld);
        end
        total++;
        if (drop_a !== exp_drop) begin
            bad++;
            $display("FAIL rng_drop: got %0d want %0d",
                     drop_a, exp_drop);
        end
    endtask

    task automatic test_clk_en();
        logic xf, wr, rdy, dn, bz, pwe;
        logic [18:0] wa, padr;
        logic [7:0] wd, pdat;
        int sent, got, ord_err, rdy_err, frz_err;
        sel = 1'b0;
        sent = 0; got = 0; ord_err = 0; rdy_err = 0; frz_err = 0;
        for (int c = 0; c < 200 && got < 16; c++) begin
            en  = (c % 2 == 0);
            vld = (sent < 16);
            px  = 12'(100 + sent);
            py  = 12'd3;
            pd  = 8'(sent * 7 + 1);
            pwe = we_a; padr = adr_a; pdat = dat_a;
            tick(xf, wr, wa, wd, rdy, dn, bz);
            if (!en && rdy) rdy_err++;
            if (!en && (we_a !== pwe || adr_a !== padr
                        || dat_a !== pdat)) frz_err++;
            if (xf) sent++;
            if (wr) begin
                if (wa !== 19'(2500 + got)
                    || wd !== 8'(got * 7 + 1)) ord_err++;
                got++;
            end
        end
        en = 1'b1; vld = 1'b0;
        total++;
        if (got !== 16) begin
            bad++;
            $display("FAIL ce_count: got %0d want 16", got);
        end
        total++;
        if (ord_err !== 0) begin
            bad++;
            $display("FAIL ce_order: got %0d errors want 0", ord_err);
        end
        total++;
        if (rdy_err !== 0) begin
            bad++;
            $display("FAIL ce_rdy: got %0d rdy-while-off want 0",
                     rdy_err);
        end
        total++;
        if (frz_err !== 0) begin
            bad++;
            $display("FAIL ce_freeze: got %0d changes want 0", frz_err);
        end
    endtask

    task automatic test_clear();
        logic xf, wr, rdy, dn, bz, rdy_after;
        logic [18:0] wa;
        logic [7:0] wd;
        logic [18:0] ea [3];
        logic [7:0] ed [3];
        int sent, nw, seq_err, ndone, viol, dadr_err, phase, extra;
        ea = '{19'd17, 19'd18, 19'd127};
        ed = '{8'h21, 8'h22, 8'h23};
        sel = 1'b1; cv = 8'h00; rdy_after = 1'b0;
        sent = 0; nw = 0; seq_err = 0; ndone = 0;
        viol = 0; dadr_err = 0; phase = 0; extra = 0;
        for (int c = 0; c < 400 && phase < 3; c++) begin
            vld = (sent < 3);
            px  = (sent == 0) ? 12'd1 : (sent == 1) ? 12'd2 : 12'd15;
            py  = (sent == 2) ? 12'd7 : 12'd1;
            pd  = 8'(33 + sent);
            clr = (sent == 3 && phase == 0);
            tick(xf, wr, wa, wd, rdy, dn, bz);
            if (dn) ndone++;
            if (dn && wa !== 19'd127) dadr_err++;
            if (clr) begin
                phase = 1;
            end else if (phase == 1) begin
                if (rdy !== 1'b0 || bz !== 1'b1) viol++;
                if (dn) phase = 2;
            end else if (phase == 2) begin
                rdy_after = rdy;
                phase = 3;
            end
            if (xf) sent++;
            if (wr) begin
                if (nw < 3) begin
                    if (wa !== ea[nw] || wd !== ed[nw]) seq_err++;
                end else if (wa !== 19'(nw - 3) || wd !== 8'h00) begin
                    seq_err++;
                end
                nw++;
            end
        end
        clr = 1'b0; vld = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(xf, wr, wa, wd, rdy, dn, bz);
            if (wr || dn) extra++;
        end
        total++;
        if (nw !== 131 || seq_err !== 0) begin
            bad++;
            $display("FAIL clr_writes: got n=%0d err=%0d want 131/0",
                     nw, seq_err);
        end
        total++;
        if (ndone !== 1 || dadr_err !== 0) begin
            bad++;
            $display("FAIL clr_done: got n=%0d adr_err=%0d want 1/0",
                     ndone, dadr_err);
        end
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL clr_rdy_busy: got %0d violations want 0",
                     viol);
        end
        total++;
        if (rdy_after !== 1'b1 || extra !== 0) begin
            bad++;
            $display("FAIL clr_after: got rdy=%b extra=%0d want 1/0",
                     rdy_after, extra);
        end
    endtask

    task automatic test_clr_ignored();
        logic xf, wr, rdy, dn, bz, rdy_after, pulsed;
        logic [18:0] wa;
        logic [7:0] wd;
        int nw, seq_err, ndone, phase, extra;
        sel = 1'b1; vld = 1'b0; cv = 8'h5A;
        rdy_after = 1'b0; pulsed = 1'b0;
        nw = 0; seq_err = 0; ndone = 0; phase = 0; extra = 0;
        for (int c = 0; c < 400 && phase < 3; c++) begin
            clr = (phase == 0) || (nw == 40 && !pulsed);
            if (phase == 1 && clr) begin
                pulsed = 1'b1;
                cv = 8'hA5;
            end
            tick(xf, wr, wa, wd, rdy, dn, bz);
            if (dn) ndone++;
            if (phase == 0) begin
                phase = 1;
            end else if (phase == 1) begin
                if (dn) phase = 2;
            end else if (phase == 2) begin
                rdy_after = rdy;
                phase = 3;
            end
            if (wr) begin
                if (wa !== 19'(nw) || wd !== 8'h5A) seq_err++;
                nw++;
            end
        end
        clr = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(xf, wr, wa, wd, rdy, dn, bz);
            if (wr || dn) extra++;
        end
        total++;
        if (nw !== 128 || seq_err !== 0) begin
            bad++;
            $display("FAIL ign_writes: got n=%0d err=%0d want 128/0",
                     nw, seq_err);
        end
        total++;
        if (ndone !== 1 || extra !== 0) begin
            bad++;
            $display("FAIL ign_once: got done=%0d extra=%0d want 1/0",
                     ndone, extra);
        end
        total++;
        if (rdy_after !== 1'b1) begin
            bad++;
            $display("FAIL ign_rdy: got %b want 1", rdy_after);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic hit;
        logic [7:0] hdat;
        int ndone, nwr;
        sel = 1'b0; vld = 1'b0; cv = 8'h77; clr = 1'b1;
        hit = 1'b0; hdat = '0; ndone = 0; nwr = 0;
        @(posedge clk);
        #1 clr = 1'b0;
        for (int c = 0; c < 1500 && !hit; c++) begin
            if (done_a) ndone++;
            if (we_a && adr_a == 19'd1000) begin
                hit = 1'b1;
                hdat = dat_a;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        total++;
        if (hit !== 1'b1 || hdat !== 8'h77) begin
            bad++;
            $display("FAIL rmc_reach: got hit=%b dat=%h want 1/77",
                     hit, hdat);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (we_a !== 1'b0 || adr_a !== 19'd0 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL rmc_async: got we=%b adr=%0d busy=%b want 0/0/0",
                     we_a, adr_a, busy_a);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        total++;
        if (pa.in_rdy !== 1'b1) begin
            bad++;
            $display("FAIL rmc_rdy: got %b want 1", pa.in_rdy);
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done_a) ndone++;
            if (we_a) nwr++;
        end
        total++;
        if (ndone !== 0 || nwr !== 0) begin
            bad++;
            $display("FAIL rmc_after: got done=%0d writes=%0d want 0/0",
                     ndone, nwr);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_range();
        test_clk_en();
        test_clear();
        test_clr_ignored();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/video_ram_writer.md
Name: video_ram_writer

Overview:
- Write-side front end for the video index RAM: accepts computed pixels (x, y, colour index) from the fractal engine over a valid/ready handshake and converts them to linear RAM writes.
- Buffers pixels in a small FIFO and performs a full-screen clear with a fill value on command.
- Drives the write port (we/adr/dat) of the dual-port index RAM whose read side feeds the synchronous video pipeline.

Parameters:
- H_ACTIVE, 800, horizontal resolution in pixels
- V_ACTIVE, 600, vertical resolution in lines
- HCW, 12, x coordinate width
- VCW, 12, y coordinate width
- IMAW, 19, index memory address width
- IMDW, 8, index memory data width
- FD, 4, FIFO depth; power of two, at least 2

Ports:
- clk  in  1  write clock
- rst  in  1  reset; asynchronous, active-high
- clk_en  in  1  clock enable; all state advances only when high
- clr  in  1  single-cycle request to clear the frame
- clr_val  in  IMDW  fill index used by clear; sampled when clr is accepted
- in_vld  in  1  pixel valid
- in_rdy  out  1  pixel ready
- in_x  in  HCW  pixel x
- in_y  in  VCW  pixel y
- in_dat  in  IMDW  pixel colour index
- busy  out  1  high when not RUN, or when s1/FIFO is non-empty
- done  out  1  one enabled-cycle pulse when a clear completes
- drop_cnt  out  16  count of out-of-range pixels
- vram_we  out  1  RAM write enable
- vram_adr_w  out  IMAW  RAM write address
- vram_dat_w  out  IMDW  RAM write data

Behaviour:
- Reset: state RUN; s1 empty; FIFO empty; clear counter 0.
- Reset values of outputs: vram_we=0, vram_adr_w=0, vram_dat_w=0, done=0, drop_cnt=0.
- in_rdy is combinational: in_rdy = (state==RUN) && clk_en && (fifo_cnt + s1_vld < FD).
- A transfer occurs when in_vld && in_rdy.
- Stage s1, on transfer:
  - registers adr = in_y*H_ACTIVE + in_x, truncated to IMAW; the product and sum are computed at full width before truncation.
  - registers in_dat.
  - sets s1_vld only when in_x < H_ACTIVE and in_y < V_ACTIVE.
- Out-of-range pixels complete the handshake, are discarded, and increment drop_cnt (see Optional Feature).
- s1 pushes into the FIFO on the next enabled cycle, unconditionally. Headroom is guaranteed by the in_rdy rule.
- Output stage, each enabled cycle in RUN or DRAIN:
  - if the FIFO is non-empty: pop the head, then register vram_we=1, vram_adr_w and vram_dat_w.
  - otherwise: vram_we=0.
- Latency: a transfer in enabled cycle N, with s1 and FIFO empty, gives vram_we=1 in enabled cycle N+3. Throughput is one pixel per enabled cycle.
- Order: writes are issued in acceptance order. Push and pop in the same cycle leave fifo_cnt unchanged.
- States:
  - RUN: normal operation. clr=1 -> DRAIN; clr_val is latched.
  - DRAIN: in_rdy=0. When s1 and the FIFO are both empty -> CLEAR, with the counter set to 0.
  - CLEAR:
    - each enabled cycle writes vram_we=1, adr=counter, dat=latched clr_val, then increments the counter.
    - after writing adr H_ACTIVE*V_ACTIVE-1 -> RUN; done pulses on that last write cycle.
- clr while in DRAIN or CLEAR is ignored; there is no queued second clear.
- clk_en=0 freezes all registers; vram_we holds its value. The RAM write port shares clk_en.
- Asynchronous reset mid-clear: aborts the clear, returns to RUN, loses buffered pixels, and clears vram_we immediately.
- Pixel at x=H_ACTIVE-1, y=V_ACTIVE-1 maps to adr 479999 with default parameters. No wrap occurs inside the frame.

Optional Feature:
- Macro VIDEO_RAM_WRITER_STATS_EN.
- Defined: drop_cnt counts discarded out-of-range pixels. It saturates at 0xFFFF, resets only on rst, and increments at most once per cycle.
- Undefined: drop_cnt is constant 0 and the counter logic is removed. Out-of-range pixels are still discarded silently.

Test Plan:
- Reset, then hold in_vld=1 with x=5, y=2, dat=0x3C -> first write vram_we=1, adr=1605, dat=0x3C exactly 3 enabled cycles after the first transfer.
- Accept x=799, y=599, dat=0xFF, then x=800, y=0 -> single write to adr 479999; with the macro, drop_cnt=1; without it, drop_cnt=0.
- Stream 16 pixels with in_vld=1 continuously and clk_en toggling 1,0,1,0 -> 16 writes in acceptance order; no write on a clk_en=0 cycle; in_rdy=0 whenever clk_en=0.
- Push 3 pixels then assert clr with clr_val=0x00 -> the 3 pixel writes complete first, then 480000 writes to adr 0..479999 with dat=0x00; in_rdy=0 and busy=1 throughout; done pulses on the adr 479999 write.
- Pulse clr again during CLEAR -> ignored; exactly one done; in_rdy returns to 1 the cycle after done.
- Assert rst at clear address 1000 -> vram_we=0 immediately; state RUN; in_rdy=1 on the first enabled cycle after rst falls; done never pulses.
